stopwatch_core: RTL
===================

# stopwatch_core

Timekeeping core of the stopwatch. It counts elapsed time as BCD minutes:seconds.centiseconds while the run control is low, and supports a synchronous clear and a lap (split) hold that freezes the displayed value while counting continues. The `pause` level comes from the start/stop toggle block, which resets high, so the stopwatch is stopped after reset. The `disp_*` outputs feed the seven-segment scan driver.

## Interface
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 100, centisecond tick rate. DIV = CLK_HZ/TICK_HZ, and DIV must be at least 2.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- pause  in  1  level; 1 = stopped, 0 = counting. Already synchronous to clk.
- clear  in  1  single-cycle pulse, synchronous; zeroes the time.
- lap  in  1  single-cycle pulse, synchronous; toggles the lap hold.
- disp_min  out  8  BCD minutes {tens, ones}, 00..59.
- disp_sec  out  8  BCD seconds {tens, ones}, 00..59.
- disp_cs  out  8  BCD centiseconds {tens, ones}, 00..99.
- held  out  1  1 = display frozen at the lap value.
- running  out  1  combinational `~pause`.
- wrap  out  1  one-cycle pulse on rollover from 59:59.99 to 00:00.00.

## Operation
- **State.** Prescaler `presc` (width clog2(DIV)), six BCD live digits, six BCD lap digits, `held`, `wrap`.
- **Reset.** All digits 0, `presc` 0, `held` 0, `wrap` 0, so `disp_*` = 00:00.00. `running` = 0 while `pause` = 1.
- **Prescaler.** When `pause` = 0, `presc` counts 0..DIV-1.
  - The edge with `presc` == DIV-1 is a tick: `presc` ← 0 and the live time advances by 0.01 s.
  - When `pause` = 1, `presc` and the time hold their values and are not cleared. Resuming continues the partial period.
- **BCD carry chain.** One tick increments cs ones.
  - Each digit wraps 9→0 and carries into the next.
  - cs tens, sec ones and min ones are 0..9; sec tens and min tens are 0..5.
  - All carries resolve on the same edge; no intermediate non-BCD value is ever visible.
- **Rollover.** A tick at 59:59.99 gives 00:00.00 with `wrap` = 1 for exactly that one cycle. Counting continues.
- **Clear.**
  - `presc` ← 0, live time ← 0, `held` ← 0, lap digits ← 0.
  - The run state is unaffected. If `pause` = 0, the first tick after clear occurs DIV cycles later.
  - Clear takes priority over a coincident tick and over lap.
- **Lap.**
  - With `held` = 0: lap digits ← the live time present before the edge (a coincident tick is not included), and `held` ← 1.
  - With `held` = 1: `held` ← 0.
  - Lap works whether paused or running. The live count is never disturbed by lap.
- **Display.** `disp_*` = `held` ? lap digits : live digits. This is a combinational mux of registers.

## Timing
- Time update latency: digits change on the clock edge where `presc` == DIV-1 and `pause` = 0. They are visible in the following cycle.
- After `pause` falls from the post-reset state, the first increment lands on the DIV-th rising edge with `pause` = 0.
- Exactly one tick every DIV clocks while running; no drift.
- `clear` and `lap` take effect on the edge where they are sampled high. Outputs change the next cycle.
- `running` follows `pause` with zero cycles of latency.
- `wrap` is high in the same cycle the digits first read 00:00.00 after rollover.
- Asynchronous `rst` mid-count: all state clears immediately and outputs read 00:00.00. Operation resumes on the first edge after release.

## Test plan
DIV = 10 throughout (CLK_HZ = 1000, TICK_HZ = 100).
1. **Reset and start.** Reset, then `pause` = 1 for 50 cycles: `disp` stays 00:00.00, `running` = 0. Drop `pause`: `disp_cs` = 0x01 after exactly 10 edges, and 0x10 after 100 edges.
2. **Carry chain.** Run 6000 ticks from zero: `disp` reads 01:00.00. Check the 00:09.99 → 00:10.00 and 00:59.99 → 01:00.00 transitions on a single edge.
3. **Pause mid-period.** Run 15 cycles, pause for 40, resume: the increment to 00:00.02 occurs 5 cycles after resume.
4. **Lap.**
   - Pulse `lap` at live 00:00.37: `held` = 1 and `disp` stays 00:00.37 while live counting continues.
   - Pulse `lap` again: `disp` jumps to the live value.
   - Pulse `lap` on a tick edge: the captured value excludes that tick.
5. **Clear priority.** Pulse `clear` and `lap` together while `held` = 1 and running: `disp` = 00:00.00, `held` = 0, and counting resumes with the first tick 10 cycles later.
6. **Rollover and async reset.** Preload by running to 59:59.99 and tick: `disp` = 00:00.00 and `wrap` is high for exactly 1 cycle. Assert `rst` between edges: outputs are 0 immediately.

Source files
------------

// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
//
// Timekeeping core of the stopwatch. It counts elapsed time as BCD
// mm:ss.cc while pause is low. It also provides a synchronous clear and a
// lap hold. The lap hold freezes the displayed value while the live count
// keeps running.
//
// Parameters
//   CLK_HZ   input clock frequency
//   TICK_HZ  centisecond tick rate; DIV = CLK_HZ/TICK_HZ must be >= 2
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   pause    level, 1 = stopped, 0 = counting (synchronous to clk)
//   clear    one-cycle pulse, zeroes live time, lap digits and held
//   lap      one-cycle pulse, toggles the lap hold
//   disp_min BCD minutes {tens, ones}
//   disp_sec BCD seconds {tens, ones}
//   disp_cs  BCD centiseconds {tens, ones}
//   held     display is showing the frozen lap value
//   running  combinational ~pause
//   wrap     one-cycle pulse on rollover 59:59.99 -> 00:00.00
// ---------------------------------------------------------------------------
module stopwatch_core #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       clear,
    input  logic       lap,
    output logic [7:0] disp_min,
    output logic [7:0] disp_sec,
    output logic [7:0] disp_cs,
    output logic       held,
    output logic       running,
    output logic       wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    // Per-digit upper limit, packed as {min tens, min ones, sec tens,
    // sec ones, cs tens, cs ones}. The value reads as the time 59:59.99.
    localparam logic [23:0] DIG_LIM = 24'h59_59_99;

    // One BCD digit step. It returns {carry_out, next_digit}. A digit that
    // sits at its limit wraps to 0 and carries when it is incremented.
    function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                            input logic [3:0] lim,
                                            input logic       cin);
        if (!cin)
            return {1'b0, d};
        else if (d == lim)
            return {1'b1, 4'd0};
        else
            return {1'b0, d + 4'd1};
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   live_q, live_d;
    logic [23:0]   lap_q, lap_d;
    logic          held_q, held_d;
    logic          wrap_q, wrap_d;

    logic          tick;
    logic          cy;
    logic [4:0]    step;
    logic [23:0]   live_inc;

    always_comb begin
        tick = ~pause && (presc_q == PRESC_LAST);

        // While paused, the prescaler holds its partial period.
        presc_d = presc_q;
        if (!pause)
            presc_d = tick ? '0 : presc_q + 1'b1;
        if (clear)
            presc_d = '0;

        // The whole carry chain resolves in one pass, so only legal BCD
        // values are ever registered.
        cy       = tick;
        step     = '0;
        live_inc = live_q;
        for (int i = 0; i < 6; i++) begin
            step                = bcd_step(live_q[4*i +: 4], DIG_LIM[4*i +: 4], cy);
            live_inc[4*i +: 4]  = step[3:0];
            cy                  = step[4];
        end

        // A carry out of minute tens means the count rolled over from
        // 59:59.99. Clear takes priority over the tick.
        live_d = clear ? '0 : live_inc;
        wrap_d = cy & ~clear;

        // The lap capture takes the pre-edge live value, so a tick on the
        // same edge is not included.
        lap_d  = lap_q;
        held_d = held_q;
        if (clear) begin
            lap_d  = '0;
            held_d = 1'b0;
        end else if (lap) begin
            if (!held_q) begin
                lap_d  = live_q;
                held_d = 1'b1;
            end else begin
                held_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            live_q  <= '0;
            lap_q   <= '0;
            held_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            live_q  <= live_d;
            lap_q   <= lap_d;
            held_q  <= held_d;
            wrap_q  <= wrap_d;
        end
    end

    assign disp_min = held_q ? lap_q[23:16] : live_q[23:16];
    assign disp_sec = held_q ? lap_q[15:8]  : live_q[15:8];
    assign disp_cs  = held_q ? lap_q[7:0]   : live_q[7:0];
    assign held     = held_q;
    assign wrap     = wrap_q;
    assign running  = ~pause;

endmodule
